// File: rtl/vixen_mem_pkg.sv
// Shared types and constants for the memory-port arbitration logic.
//   owner_t              : which requester owns a grant or an in-flight read
//   STARVE_LIMIT_DEFAULT : default denied-cycle count before a forced DMA grant
//   ADDR_W / DATA_W      : memory port 1 address and data widths
package vixen_mem_pkg;

  localparam int unsigned ADDR_W               = 16;
  localparam int unsigned DATA_W               = 16;
  localparam int unsigned STARVE_LIMIT_DEFAULT = 8;

  typedef enum logic [1:0] {
    NONE,
    CPU,
    DMA
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the CPU request, DMA request and memory port 1 signals around the
// arbiter.
//   slave  : arbiter view (takes CPU/DMA requests and mem_rdata, drives grants
//            and the memory port)
//   master : system view (drives requests and mem_rdata, observes the rest)
interface mem_arbiter_if;

  // CPU side
  logic                              cpu_en;
  logic                              cpu_wr;
  logic                              cpu_wide;
  logic [vixen_mem_pkg::ADDR_W-1:0]  cpu_addr;
  logic [vixen_mem_pkg::DATA_W-1:0]  cpu_wdata;
  logic [vixen_mem_pkg::DATA_W-1:0]  cpu_rdata;
  logic                              cpu_wait;

  // DMA side
  logic                              dma_req;
  logic                              dma_wr;
  logic                              dma_wide;
  logic [vixen_mem_pkg::ADDR_W-1:0]  dma_addr;
  logic [vixen_mem_pkg::DATA_W-1:0]  dma_wdata;
  logic                              dma_ack;
  logic [vixen_mem_pkg::DATA_W-1:0]  dma_rdata;
  logic                              dma_rvalid;

  // Memory port 1
  logic                              mem_en;
  logic                              mem_wr;
  logic                              mem_wide;
  logic [vixen_mem_pkg::ADDR_W-1:0]  mem_addr;
  logic [vixen_mem_pkg::DATA_W-1:0]  mem_wdata;
  logic [vixen_mem_pkg::DATA_W-1:0]  mem_rdata;

  modport slave (
    input  cpu_en, cpu_wr, cpu_wide, cpu_addr, cpu_wdata,
    input  dma_req, dma_wr, dma_wide, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_wait,
    output dma_ack, dma_rdata, dma_rvalid,
    output mem_en, mem_wr, mem_wide, mem_addr, mem_wdata
  );

  modport master (
    output cpu_en, cpu_wr, cpu_wide, cpu_addr, cpu_wdata,
    output dma_req, dma_wr, dma_wide, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_wait,
    input  dma_ack, dma_rdata, dma_rvalid,
    input  mem_en, mem_wr, mem_wide, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_starve.sv
// DMA starvation counter. Counts consecutive cycles in which the DMA request
// is pending but not granted, saturating at STARVE_LIMIT, and raises
// force_dma once the limit is reached.
//   clk, nreset : system clock, asynchronous active-low reset
//   dma_req     : DMA request pending
//   dma_grant   : DMA granted this cycle
//   force_dma   : DMA must be granted this cycle, ahead of the CPU
module mem_arb_starve
  import vixen_mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic nreset,
  input  logic dma_req,
  input  logic dma_grant,
  output logic force_dma
);

  localparam logic [7:0] Limit = 8'(STARVE_LIMIT);

  logic [7:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!dma_req || dma_grant) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != Limit) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // With a limit of 0 this holds whenever dma_req is high: DMA always wins.
  assign force_dma = dma_req && (starve_cnt_q == Limit);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for memory port 1. The CPU wins by default, the DMA
// master takes idle cycles, and a starved DMA request is forced through with
// a one-cycle CPU stall. Read data is routed back by remembering who issued
// the previous cycle's read.
//   clk, nreset : system clock, asynchronous active-low reset
//   bus         : CPU request, DMA request and memory port signals (slave view)
module mem_arbiter
  import vixen_mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input logic          clk,
  input logic          nreset,
  mem_arbiter_if.slave bus
);

  logic   force_dma;
  owner_t grant;
  owner_t rd_owner_q, rd_owner_d;

  mem_arb_starve #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk       (clk),
    .nreset    (nreset),
    .dma_req   (bus.dma_req),
    .dma_grant (bus.dma_ack),
    .force_dma (force_dma)
  );

  // Grant is combinational; nothing is granted while reset is held so the
  // memory never sees a stray access during reset.
  always_comb begin
    grant = NONE;
    if (nreset) begin
      if (force_dma) begin
        grant = DMA;
      end else if (bus.cpu_en) begin
        grant = CPU;
      end else if (bus.dma_req) begin
        grant = DMA;
      end
    end
  end

  always_comb begin
    bus.cpu_wait  = nreset && bus.cpu_en && force_dma;
    bus.dma_ack   = (grant == DMA);
    bus.mem_en    = (grant != NONE);
    bus.mem_wr    = bus.cpu_wr;
    bus.mem_wide  = bus.cpu_wide;
    bus.mem_addr  = bus.cpu_addr;
    bus.mem_wdata = bus.cpu_wdata;
    if (grant == DMA) begin
      bus.mem_wr    = bus.dma_wr;
      bus.mem_wide  = bus.dma_wide;
      bus.mem_addr  = bus.dma_addr;
      bus.mem_wdata = bus.dma_wdata;
    end
  end

  // Only reads produce a response next cycle.
  always_comb begin
    rd_owner_d = NONE;
    if (grant != NONE && !bus.mem_wr) begin
      rd_owner_d = grant;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rd_owner_q <= NONE;
    end else begin
      rd_owner_q <= rd_owner_d;
    end
  end

  assign bus.dma_rvalid = (rd_owner_q == DMA);
  assign bus.dma_rdata  = bus.mem_rdata;
  assign bus.cpu_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic nreset;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter_if bus8 ();
  mem_arbiter_if bus0 ();

  mem_arbiter #(.STARVE_LIMIT(8)) dut8 (.clk(clk), .nreset(nreset), .bus(bus8));
  mem_arbiter #(.STARVE_LIMIT(0)) dut0 (.clk(clk), .nreset(nreset), .bus(bus0));

  // Memory model: synchronous read returning address ^ 16'hA5A5.
  always @(posedge clk) begin
    if (bus8.mem_en && !bus8.mem_wr) bus8.mem_rdata <= bus8.mem_addr ^ 16'hA5A5;
    if (bus0.mem_en && !bus0.mem_wr) bus0.mem_rdata <= bus0.mem_addr ^ 16'hA5A5;
  end

  typedef struct {
    logic        cpu_en, cpu_wr, cpu_wide;
    logic [15:0] cpu_addr, cpu_wdata;
    logic        dma_req, dma_wr, dma_wide;
    logic [15:0] dma_addr, dma_wdata;
    logic        e_wait, e_ack, e_en, e_wr, e_wide;
    logic [15:0] e_addr, e_wdata;
    logic        e_rvalid, chk_rd;
    logic [15:0] e_rdata;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic set_cpu(input logic en, input logic wr, input logic wide,
                         input logic [15:0] addr, input logic [15:0] wdata);
    bus8.cpu_en = en; bus8.cpu_wr = wr; bus8.cpu_wide = wide;
    bus8.cpu_addr = addr; bus8.cpu_wdata = wdata;
  endtask

  task automatic set_dma(input logic req, input logic wr, input logic wide,
                         input logic [15:0] addr, input logic [15:0] wdata);
    bus8.dma_req = req; bus8.dma_wr = wr; bus8.dma_wide = wide;
    bus8.dma_addr = addr; bus8.dma_wdata = wdata;
  endtask

  initial begin
    // cpu en/wr/wide/addr/wdata, dma req/wr/wide/addr/wdata,
    // exp wait/ack/en/wr/wide/addr/wdata, rvalid, chk_rd, rdata
    vecs[0] = '{0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000,
                0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000};
    vecs[1] = '{1, 0, 1, 16'h1234, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000,
                0, 0, 1, 0, 1, 16'h1234, 16'h0000, 0, 0, 16'h0000};
    vecs[2] = '{0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000,
                0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'hB791};
    vecs[3] = '{0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h8000, 16'h0000,
                0, 1, 1, 0, 0, 16'h8000, 16'h0000, 0, 0, 16'h0000};
    vecs[4] = '{0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000,
                0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h25A5};
    vecs[5] = '{1, 1, 1, 16'h0010, 16'hBEEF, 0, 0, 0, 16'h0000, 16'h0000,
                0, 0, 1, 1, 1, 16'h0010, 16'hBEEF, 0, 0, 16'h0000};
    vecs[6] = '{0, 0, 0, 16'h0000, 16'h0000, 1, 1, 1, 16'h0020, 16'h1111,
                0, 1, 1, 1, 1, 16'h0020, 16'h1111, 0, 0, 16'h0000};
    vecs[7] = '{1, 0, 1, 16'h4000, 16'h0000, 1, 0, 0, 16'h5000, 16'h0000,
                0, 0, 1, 0, 1, 16'h4000, 16'h0000, 0, 0, 16'h0000};
    vecs[8] = '{0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h5000, 16'h0000,
                0, 1, 1, 0, 0, 16'h5000, 16'h0000, 0, 1, 16'hE5A5};
    vecs[9] = '{0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000,
                0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'hF5A5};

    // Reset with both requesters asserted: nothing may be granted.
    nreset = 1'b0;
    set_cpu(1, 0, 1, 16'h0100, 16'h0000);
    set_dma(1, 0, 1, 16'h0200, 16'h0000);
    bus0.cpu_en = 1; bus0.cpu_wr = 0; bus0.cpu_wide = 1;
    bus0.cpu_addr = 16'h0C00; bus0.cpu_wdata = 16'h0000;
    bus0.dma_req = 1; bus0.dma_wr = 0; bus0.dma_wide = 1;
    bus0.dma_addr = 16'hD000; bus0.dma_wdata = 16'h0000;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_en", 32'(bus8.mem_en), 32'd0);
    chk("rst_ack", 32'(bus8.dma_ack), 32'd0);
    chk("rst_wait", 32'(bus8.cpu_wait), 32'd0);
    chk("rst_rvalid", 32'(bus8.dma_rvalid), 32'd0);
    chk("rst0_wait", 32'(bus0.cpu_wait), 32'd0);
    chk("rst0_mem_en", 32'(bus0.mem_en), 32'd0);
    set_cpu(0, 0, 0, 16'h0000, 16'h0000);
    set_dma(0, 0, 0, 16'h0000, 16'h0000);
    bus0.cpu_en = 0; bus0.dma_req = 0;
    @(negedge clk);
    nreset = 1'b1;

    // Table-driven single-cycle vectors on the limit-8 arbiter.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      set_cpu(vecs[i].cpu_en, vecs[i].cpu_wr, vecs[i].cpu_wide, vecs[i].cpu_addr,
              vecs[i].cpu_wdata);
      set_dma(vecs[i].dma_req, vecs[i].dma_wr, vecs[i].dma_wide, vecs[i].dma_addr,
              vecs[i].dma_wdata);
      #1;
      chk($sformatf("v%0d_wait", i), 32'(bus8.cpu_wait), 32'(vecs[i].e_wait));
      chk($sformatf("v%0d_ack", i), 32'(bus8.dma_ack), 32'(vecs[i].e_ack));
      chk($sformatf("v%0d_mem_en", i), 32'(bus8.mem_en), 32'(vecs[i].e_en));
      chk($sformatf("v%0d_rvalid", i), 32'(bus8.dma_rvalid), 32'(vecs[i].e_rvalid));
      if (vecs[i].e_en) begin
        chk($sformatf("v%0d_mem_wr", i), 32'(bus8.mem_wr), 32'(vecs[i].e_wr));
        chk($sformatf("v%0d_mem_wide", i), 32'(bus8.mem_wide), 32'(vecs[i].e_wide));
        chk($sformatf("v%0d_mem_addr", i), 32'(bus8.mem_addr), 32'(vecs[i].e_addr));
        chk($sformatf("v%0d_mem_wdata", i), 32'(bus8.mem_wdata), 32'(vecs[i].e_wdata));
      end
      if (vecs[i].chk_rd) begin
        chk($sformatf("v%0d_cpu_rdata", i), 32'(bus8.cpu_rdata), 32'(vecs[i].e_rdata));
      end
      if (vecs[i].e_rvalid) begin
        chk($sformatf("v%0d_dma_rdata", i), 32'(bus8.dma_rdata), 32'(vecs[i].e_rdata));
      end
    end

    // Starvation: CPU busy every cycle, DMA write pending back to back.
    // Two rounds: 8 CPU grants, then a forced DMA grant with a CPU stall.
    for (int r = 0; r < 2; r++) begin
      for (int k = 1; k <= 9; k++) begin
        @(negedge clk);
        set_cpu(1, 0, 1, 16'h0300, 16'h0000);
        set_dma(1, 1, 1, 16'h0700, 16'hCAFE);
        #1;
        if (k < 9) begin
          chk($sformatf("st%0d_%0d_ack", r, k), 32'(bus8.dma_ack), 32'd0);
          chk($sformatf("st%0d_%0d_wait", r, k), 32'(bus8.cpu_wait), 32'd0);
          chk($sformatf("st%0d_%0d_addr", r, k), 32'(bus8.mem_addr), 32'h0300);
        end else begin
          chk($sformatf("st%0d_force_ack", r), 32'(bus8.dma_ack), 32'd1);
          chk($sformatf("st%0d_force_wait", r), 32'(bus8.cpu_wait), 32'd1);
          chk($sformatf("st%0d_force_addr", r), 32'(bus8.mem_addr), 32'h0700);
          chk($sformatf("st%0d_force_wr", r), 32'(bus8.mem_wr), 32'd1);
          chk($sformatf("st%0d_force_wdata", r), 32'(bus8.mem_wdata), 32'hCAFE);
        end
      end
    end
    @(negedge clk);
    set_dma(0, 0, 0, 16'h0000, 16'h0000);
    #1;
    chk("st_after_ack", 32'(bus8.dma_ack), 32'd0);
    chk("st_after_wait", 32'(bus8.cpu_wait), 32'd0);
    chk("st_after_addr", 32'(bus8.mem_addr), 32'h0300);

    // Build the counter up to 5, reset, then the full 9-cycle wait must apply.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      set_cpu(1, 0, 1, 16'h0300, 16'h0000);
      set_dma(1, 1, 1, 16'h0700, 16'hCAFE);
    end
    @(negedge clk);
    nreset = 1'b0;
    #1;
    chk("rc_rst_mem_en", 32'(bus8.mem_en), 32'd0);
    chk("rc_rst_wait", 32'(bus8.cpu_wait), 32'd0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      nreset = 1'b1;
      #1;
      chk($sformatf("rc%0d_ack", k), 32'(bus8.dma_ack), (k == 9) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    set_cpu(0, 0, 0, 16'h0000, 16'h0000);
    set_dma(0, 0, 0, 16'h0000, 16'h0000);

    // Reset pulsed during a granted DMA read: no read response afterwards.
    @(negedge clk);
    set_dma(1, 0, 1, 16'h9000, 16'h0000);
    #1;
    chk("rmr_ack", 32'(bus8.dma_ack), 32'd1);
    chk("rmr_mem_en", 32'(bus8.mem_en), 32'd1);
    #1;
    nreset = 1'b0;
    #1;
    chk("rmr_rst_mem_en", 32'(bus8.mem_en), 32'd0);
    chk("rmr_rst_ack", 32'(bus8.dma_ack), 32'd0);
    @(negedge clk);
    nreset = 1'b1;
    set_dma(0, 0, 0, 16'h0000, 16'h0000);
    #1;
    chk("rmr_rvalid0", 32'(bus8.dma_rvalid), 32'd0);
    @(negedge clk);
    #1;
    chk("rmr_rvalid1", 32'(bus8.dma_rvalid), 32'd0);

    // STARVE_LIMIT=0: DMA wins every cycle and the CPU waits throughout.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus0.cpu_en = 1; bus0.dma_req = 1;
      #1;
      chk($sformatf("l0_%0d_ack", k), 32'(bus0.dma_ack), 32'd1);
      chk($sformatf("l0_%0d_wait", k), 32'(bus0.cpu_wait), 32'd1);
      chk($sformatf("l0_%0d_addr", k), 32'(bus0.mem_addr), 32'hD000);
      chk($sformatf("l0_%0d_rvalid", k), 32'(bus0.dma_rvalid), (k > 0) ? 32'd1 : 32'd0);
      if (k > 0) chk($sformatf("l0_%0d_rdata", k), 32'(bus0.dma_rdata), 32'h75A5);
    end
    @(negedge clk);
    bus0.dma_req = 0;
    #1;
    chk("l0_cpu_ack", 32'(bus0.dma_ack), 32'd0);
    chk("l0_cpu_wait", 32'(bus0.cpu_wait), 32'd0);
    chk("l0_cpu_addr", 32'(bus0.mem_addr), 32'h0C00);
    @(negedge clk);
    bus0.cpu_en = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
